// File: rtl/req_pend_pkg.sv
// Shared types and constants for the four-channel request pending arbiter.
// The REQ_OVF_CNT_EN build option only affects the top level.
package req_pend_pkg;

   localparam int NREQ = 4;
   localparam int IDW  = 2;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_OFFER = 1'b1
   } state_t;

   localparam logic [7:0] OVF_MAX = 8'd255;

   // One-hot mask for a channel id; used to clear the accepted pending bit.
   function automatic logic [NREQ-1:0] onehot(input logic [IDW-1:0] id);
      logic [NREQ-1:0] m;
      m = '0;
      m[id] = 1'b1;
      return m;
   endfunction

endpackage

// File: rtl/req_pri_pick.sv
// Combinational highest-index-wins picker over the request vector.
// The id output is forced to 0 when no bit is set, so it is never undefined.
module req_pri_pick
   import req_pend_pkg::*;
(
   input  logic [NREQ-1:0] v,
   output logic            any,
   output logic [IDW-1:0]  id
);

   always_comb begin
      id = '0;
      // Ascending scan so the highest set bit is the last to write id.
      for (int i = 0; i < NREQ; i++) begin
         if (v[i]) begin
            id = IDW'(i);
         end
      end
   end

   assign any = |v;

endmodule

// File: rtl/req_pend_arb_4.sv
// Sticky request latch with a highest-index valid/ready grant stage.
// Define REQ_OVF_CNT_EN to add the saturating overflow counter output ovf_cnt_o.
module req_pend_arb_4
   import req_pend_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic [NREQ-1:0] req_i,
   output logic            gnt_valid,
   output logic [IDW-1:0]  gnt_id,
   input  logic            gnt_ready,
`ifdef REQ_OVF_CNT_EN
   output logic [7:0]      ovf_cnt_o,
`endif
   output logic [NREQ-1:0] pend_o
);

   state_t          state_q, state_d;
   logic [NREQ-1:0] pend_q, pend_d;
   logic [IDW-1:0]  gnt_id_q, gnt_id_d;

   logic            acc;
   logic [NREQ-1:0] clr;
   logic [NREQ-1:0] pend_rem;
   logic            any_cur, any_rem;
   logic [IDW-1:0]  id_cur, id_rem;

   assign acc      = (state_q == ST_OFFER) && gnt_ready;
   assign clr      = acc ? onehot(gnt_id_q) : '0;
   assign pend_rem = pend_q & ~clr;

   // Both pickers look only at registered state; req_i never reaches gnt_id directly.
   req_pri_pick u_pick_cur (
      .v   (pend_q),
      .any (any_cur),
      .id  (id_cur)
   );

   req_pri_pick u_pick_rem (
      .v   (pend_rem),
      .any (any_rem),
      .id  (id_rem)
   );

   always_comb begin
      // Set wins over clear, so a re-request in the accept cycle survives.
      pend_d   = pend_rem | req_i;
      state_d  = state_q;
      gnt_id_d = gnt_id_q;
      unique case (state_q)
         ST_IDLE: begin
            if (any_cur) begin
               state_d  = ST_OFFER;
               gnt_id_d = id_cur;
            end
         end
         ST_OFFER: begin
            if (acc) begin
               if (any_rem) begin
                  gnt_id_d = id_rem;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

`ifdef REQ_OVF_CNT_EN
   logic [7:0] ovf_cnt_q, ovf_cnt_d;
   logic       ovf_hit;

   assign ovf_hit = |(req_i & pend_q & ~clr);

   always_comb begin
      ovf_cnt_d = ovf_cnt_q;
      if (ovf_hit && (ovf_cnt_q != OVF_MAX)) begin
         ovf_cnt_d = ovf_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_cnt_q <= '0;
      end else begin
         ovf_cnt_q <= ovf_cnt_d;
      end
   end

   assign ovf_cnt_o = ovf_cnt_q;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         pend_q   <= '0;
         gnt_id_q <= '0;
      end else begin
         state_q  <= state_d;
         pend_q   <= pend_d;
         gnt_id_q <= gnt_id_d;
      end
   end

   assign gnt_valid = (state_q == ST_OFFER);
   assign gnt_id    = gnt_id_q;
   assign pend_o    = pend_q;

endmodule
